truth_table_sweeper: RTL and testbench

- Sequential stimulus-and-capture stage placed around a combinational 4-input logic function, such as one of the mux-based exercise functions.
- Upstream role: drives the function's select inputs (a,b,c,d) through every combination, 0 to 2^N-1.
- Downstream role: samples the function output for each combination into a truth-table register.
- Gives the lab board a one-shot "evaluate function" operation with start/busy/done handshake.

---
 rtl/tt_sweep_pkg.sv | 21 ++
 rtl/sweep_settle_timer.sv | 32 +++
 rtl/truth_table_sweeper.sv | 130 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep_pkg
// Description : Shared state encoding, table-width helper and settle default
//               for the truth-table sweeper.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_sweep_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int c_default_settle_cycles = 1;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sweep_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : sweep_settle_timer
// Description : 4-bit loadable down-counter with zero flag; paces how long
//               each stimulus vector is held before it is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module sweep_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign zero = (r_count == 4'd0);

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Walks vec through 0..2^N-1 and captures f_in for each value
//               into table_out, with a start/busy/done handshake.
//               Optional TRUTH_TABLE_MINTERM_COUNT_EN adds ones_count.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int N             = 4,
    parameter int SETTLE_CYCLES = c_default_settle_cycles
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   f_in,
    output logic [N-1:0]           vec,
    output logic                   busy,
    output logic                   done,
    output logic [tt_width(N)-1:0] table_out
`ifdef TRUTH_TABLE_MINTERM_COUNT_EN
    ,
    output logic [N:0]             ones_count
`endif
);

    localparam int             c_tw          = tt_width(N);
    localparam logic [N-1:0]   c_vec_last    = {N{1'b1}};
    localparam logic [N-1:0]   c_vec_one     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [3:0]     c_settle_load = 4'(SETTLE_CYCLES);

    logic [1:0]      r_state;
    logic [N-1:0]    r_vec;
    logic            r_busy;
    logic            r_done;
    logic [c_tw-1:0] r_table;

    logic w_accept;
    logic w_sample;
    logic w_timer_load;
    logic w_timer_dec;
    logic w_timer_zero;

    assign w_accept     = (r_state == ST_IDLE) && start;
    assign w_sample     = (r_state == ST_SWEEP) && w_timer_zero;
    // Reload on entry and on every advance; never on the final vector.
    assign w_timer_load = w_accept || (w_sample && (r_vec != c_vec_last));
    assign w_timer_dec  = (r_state == ST_SWEEP) && !w_timer_zero;

    sweep_settle_timer u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_timer_load),
        .load_val (c_settle_load),
        .dec      (w_timer_dec),
        .zero     (w_timer_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_table <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_SWEEP;
                        r_busy  <= 1'b1;
                        r_vec   <= '0;
                        r_table <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (w_timer_zero) begin
                        r_table[r_vec] <= f_in;
                        if (r_vec == c_vec_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_vec   <= '0;
                        end else begin
                            r_vec <= r_vec + c_vec_one;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_vec   <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign vec       = r_vec;
    assign busy      = r_busy;
    assign done      = r_done;
    assign table_out = r_table;

`ifdef TRUTH_TABLE_MINTERM_COUNT_EN
    localparam logic [N:0] c_ones_one = {{N{1'b0}}, 1'b1};

    logic [N:0] r_ones;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ones <= '0;
        end else if (w_accept) begin
            r_ones <= '0;
        end else if (w_sample && f_in) begin
            r_ones <= r_ones + c_ones_one;
        end
    end

    assign ones_count = r_ones;
`endif

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Scoreboard bench driving two sweepers (settle 0 and 2) from a
//               shared lookup-table function; honours TRUTH_TABLE_MINTERM_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    localparam int c_n  = 4;
    localparam int c_s0 = 0;
    localparam int c_s1 = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] lut;

    logic [3:0]  vec0, vec1;
    logic        busy0, busy1, done0, done1;
    logic [15:0] tbl0, tbl1;
    logic        f_in0, f_in1;
`ifdef TRUTH_TABLE_MINTERM_COUNT_EN
    logic [4:0]  oc0, oc1;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int dc0 = 0, dc1 = 0;
    int k0 = 0, k1 = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    always #5 clk = ~clk;

    // The function under evaluation is an arbitrary table indexed by vec.
    assign f_in0 = lut[vec0];
    assign f_in1 = lut[vec1];

    truth_table_sweeper #(.N(c_n), .SETTLE_CYCLES(c_s0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .f_in(f_in0),
        .vec(vec0), .busy(busy0), .done(done0), .table_out(tbl0)
`ifdef TRUTH_TABLE_MINTERM_COUNT_EN
        , .ones_count(oc0)
`endif
    );

    truth_table_sweeper #(.N(c_n), .SETTLE_CYCLES(c_s1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .f_in(f_in1),
        .vec(vec1), .busy(busy1), .done(done1), .table_out(tbl1)
`ifdef TRUTH_TABLE_MINTERM_COUNT_EN
        , .ones_count(oc1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the settle-0 instance
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst) begin
            k0 = 0;
        end else if (busy0) begin
            check("vec0_step", 32'(vec0), 32'(k0 / (c_s0 + 1)));
            check("done0_low_while_busy", 32'(done0), 0);
            k0++;
        end else begin
            if (done0) begin
                dc0++;
                if (q0.size() == 0) begin
                    check("done0_unexpected", 1, 0);
                end else begin
                    e = q0.pop_front();
                    check("table0", 32'(tbl0), 32'(e));
                    check("sweep0_len", k0, 16 * (c_s0 + 1));
                    check("vec0_at_done", 32'(vec0), 0);
`ifdef TRUTH_TABLE_MINTERM_COUNT_EN
                    check("ones0", 32'(oc0), $countones(e));
`endif
                end
            end
            k0 = 0;
        end
    end

    // Monitor for the settle-2 instance
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst) begin
            k1 = 0;
        end else if (busy1) begin
            check("vec1_step", 32'(vec1), 32'(k1 / (c_s1 + 1)));
            check("done1_low_while_busy", 32'(done1), 0);
            k1++;
        end else begin
            if (done1) begin
                dc1++;
                if (q1.size() == 0) begin
                    check("done1_unexpected", 1, 0);
                end else begin
                    e = q1.pop_front();
                    check("table1", 32'(tbl1), 32'(e));
                    check("sweep1_len", k1, 16 * (c_s1 + 1));
                    check("vec1_at_done", 32'(vec1), 0);
`ifdef TRUTH_TABLE_MINTERM_COUNT_EN
                    check("ones1", 32'(oc1), $countones(e));
`endif
                end
            end
            k1 = 0;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_vec0"},  32'(vec0),  0);
        check({tag, "_busy0"}, 32'(busy0), 0);
        check({tag, "_done0"}, 32'(done0), 0);
        check({tag, "_tbl0"},  32'(tbl0),  0);
        check({tag, "_vec1"},  32'(vec1),  0);
        check({tag, "_busy1"}, 32'(busy1), 0);
        check({tag, "_done1"}, 32'(done1), 0);
        check({tag, "_tbl1"},  32'(tbl1),  0);
`ifdef TRUTH_TABLE_MINTERM_COUNT_EN
        check({tag, "_oc0"},   32'(oc0),   0);
        check({tag, "_oc1"},   32'(oc1),   0);
`endif
    endtask

    task automatic wait_done(input int t0, input int t1);
        int i = 0;
        while ((dc0 < t0 || dc1 < t1) && i < 600) begin
            @(posedge clk);
            i++;
        end
        check("done_timeout", 32'(dc0 >= t0 && dc1 >= t1), 1);
        #1;
    endtask

    task automatic wait_vec0(input logic [3:0] v);
        int i = 0;
        while (vec0 !== v && i < 100) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("reach_vec0", 32'(vec0), 32'(v));
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_sweep(input logic [15:0] f, input bit mid_start);
        int t0, t1;
        lut = f;
        q0.push_back(f);
        q1.push_back(f);
        t0 = dc0 + 1;
        t1 = dc1 + 1;
        pulse_start();
        if (mid_start) begin
            wait_vec0(4'd7);
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_done(t0, t1);
    endtask

    initial begin
        int t0, t1;
        rst   = 1'b1;
        start = 1'b0;
        lut   = 16'hFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        run_sweep(16'hFFFF, 1'b0);
        run_sweep(16'h090C, 1'b0);
        run_sweep(16'h090C, 1'b1);

        // Reset in the middle of a sweep abandons it.
        lut = 16'h090C;
        pulse_start();
        wait_vec0(4'd5);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        check_reset("midreset");
        run_sweep(16'h090C, 1'b0);

        // Start held high: 40 sampled edges gives three settle-0 sweeps, one settle-2.
        lut = 16'hAAAA;
        for (int i = 0; i < 3; i++) q0.push_back(16'hAAAA);
        q1.push_back(16'hAAAA);
        t0 = dc0 + 3;
        t1 = dc1 + 1;
        @(posedge clk);
        #1 start = 1'b1;
        repeat (40) @(posedge clk);
        #1 start = 1'b0;
        wait_done(t0, t1);

        for (int i = 0; i < 4; i++) begin
            run_sweep(16'($urandom), 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("table0_held", 32'(tbl0), 32'(lut));
        check("table1_held", 32'(tbl1), 32'(lut));
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
